// File: rtl/debounce_sched_pkg.sv
// debounce_sched_pkg: shared FSM state type and width helpers for debounce_scheduler.
package debounce_sched_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction
  function automatic int idx_width(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction
endpackage

// File: rtl/debounce_scheduler_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(TICK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin time-multiplexed debouncer for N_BTN buttons.
// Define DEBOUNCE_RELEASE_EN to generate btn_release pulses; otherwise btn_release is 0.
module debounce_scheduler
  import debounce_sched_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 1_000_000,
  parameter int STABLE_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             busy
);
  localparam int CW = cnt_width(STABLE_TICKS);
  localparam int IW = idx_width(N_BTN);
  logic             tick, hit, last;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_BTN-1:0] sync1_q, sync2_q, level_q, level_d, press_q, press_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
`ifdef DEBOUNCE_RELEASE_EN
  logic [N_BTN-1:0] release_q, release_d;
`endif
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = '0;
`ifdef DEBOUNCE_RELEASE_EN
    release_d = '0;
`endif
    hit  = cnt_q[idx_q] + CW'(1) == CW'(STABLE_TICKS);
    last = idx_q == IW'(N_BTN - 1);
    if (state_q == IDLE) begin
      state_d = (tick && en) ? SCAN : IDLE;
      idx_d   = '0;
    end else begin
      if (sync2_q[idx_q] == level_q[idx_q]) cnt_d[idx_q] = '0;
      else if (hit) begin
        level_d[idx_q] = ~level_q[idx_q];
        cnt_d[idx_q]   = '0;
        press_d[idx_q] = ~level_q[idx_q];
`ifdef DEBOUNCE_RELEASE_EN
        release_d[idx_q] = level_q[idx_q];
`endif
      end else cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
      state_d = last ? IDLE : SCAN;
      idx_d   = last ? '0 : idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      cnt_q   <= '{default: '0};
`ifdef DEBOUNCE_RELEASE_EN
      release_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
`ifdef DEBOUNCE_RELEASE_EN
      release_q <= release_d;
`endif
    end
  end
  assign btn_level = level_q;
  assign btn_press = press_q;
  assign busy      = state_q == SCAN;
`ifdef DEBOUNCE_RELEASE_EN
  assign btn_release = release_q;
`else
  assign btn_release = '0;
`endif
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed scenarios for debounce_scheduler (N_BTN=4, TICK_DIV=8, STABLE_TICKS=3).
module tb_debounce_scheduler;
  import debounce_sched_pkg::*;
  logic       clk = 0, reset = 1, en = 1;
  logic [3:0] btn_in = '0, btn_level, btn_press, btn_release;
  logic       busy;
  int n_tests = 0, n_fail = 0, cyc = 0;

  debounce_scheduler #(.N_BTN(4), .TICK_DIV(8), .STABLE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .en(en), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // cyc counts edges after the last reset edge; cycle 0 has tick counter 0
  task automatic do_reset(input logic [3:0] b, input logic e);
    reset = 1; btn_in = '0; en = e;
    step(); step();
    reset = 0; btn_in = b; cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1; btn_in = 4'b1111; en = 1;
    step(); step();
    n_tests++; if ({btn_level, btn_press, btn_release, busy} !== 13'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0", {btn_level, btn_press, btn_release, busy}); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    n_tests++; if (dut.u_tick.cnt_q !== 3'd0) begin n_fail++; $display("FAIL reset_tickcnt: got %0d expected 0", dut.u_tick.cnt_q); end
    n_tests++; if (dut.sync2_q !== 4'd0) begin n_fail++; $display("FAIL reset_sync: got %b expected 0000", dut.sync2_q); end
  endtask

  task automatic test_clean_press();
    int rise = -1, np = 0, pc = -1, bad = 0;
    logic [3:0] pv = '0;
    do_reset(4'b0010, 1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_level != 0 && rise < 0) rise = cyc;
      if (btn_press != 0) begin np++; pv = btn_press; pc = cyc; end
      if (btn_release != 0 || (btn_level & 4'b1101) != 0) bad++;
    end
    n_tests++; if (rise != 26) begin n_fail++; $display("FAIL press_rise_cycle: got %0d expected 26", rise); end
    n_tests++; if (np != 1) begin n_fail++; $display("FAIL press_count: got %0d expected 1", np); end
    n_tests++; if (pv !== 4'b0010 || pc != 26) begin n_fail++; $display("FAIL press_pulse: got %b@%0d expected 0010@26", pv, pc); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL press_other_bits: got %0d expected 0", bad); end
    n_tests++; if (btn_level !== 4'b0010) begin n_fail++; $display("FAIL press_level: got %b expected 0010", btn_level); end
  endtask

  task automatic test_bounce();
    int mx = 0, bad = 0;
    do_reset(4'b0001, 1);
    for (int i = 0; i < 64; i++) begin
      step();
      if (cyc % 8 == 0) btn_in[0] = ~btn_in[0];
      if (int'(dut.cnt_q[0]) > mx) mx = int'(dut.cnt_q[0]);
      if (btn_level != 0 || btn_press != 0 || btn_release != 0) bad++;
    end
    n_tests++; if (mx != 1) begin n_fail++; $display("FAIL bounce_cnt_max: got %0d expected 1", mx); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bounce_outputs: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_release();
    int pc = -1, fall = -1, nr = 0, rc = -1;
    int exp_nr = `ifdef DEBOUNCE_RELEASE_EN 1 `else 0 `endif;
    logic [3:0] rv = '0;
    logic prev = 0;
    do_reset(4'b1000, 1);
    for (int i = 0; i < 60; i++) begin
      step();
      if (cyc == 28) btn_in = '0;
      if (btn_press[3]) pc = cyc;
      if (prev && !btn_level[3]) fall = cyc;
      prev = btn_level[3];
      if (btn_release != 0) begin nr++; rv = btn_release; rc = cyc; end
    end
    n_tests++; if (pc != 28) begin n_fail++; $display("FAIL release_press_cycle: got %0d expected 28", pc); end
    n_tests++; if (fall != 52) begin n_fail++; $display("FAIL release_fall_cycle: got %0d expected 52", fall); end
    n_tests++; if (nr != exp_nr) begin n_fail++; $display("FAIL release_count: got %0d expected %0d", nr, exp_nr); end
`ifdef DEBOUNCE_RELEASE_EN
    n_tests++; if (rv !== 4'b1000 || rc != 52) begin n_fail++; $display("FAIL release_pulse: got %b@%0d expected 1000@52", rv, rc); end
`endif
  endtask

  task automatic test_simultaneous();
    int ok = 0, other = 0, multi = 0, nbusy = 0;
    logic [3:0] ep;
    do_reset(4'b1111, 1);
    for (int i = 0; i < 39; i++) begin
      step();
      if (busy) nbusy++;
      if (btn_press != 0) begin
        if ($countones(btn_press) > 1) multi++;
        ep = 4'b0001 << (cyc - 25);
        if (cyc >= 25 && cyc <= 28 && btn_press === ep) ok++;
        else other++;
      end
    end
    n_tests++; if (ok != 4) begin n_fail++; $display("FAIL simul_ordered_pulses: got %0d expected 4", ok); end
    n_tests++; if (other != 0 || multi != 0) begin n_fail++; $display("FAIL simul_stray_pulses: got %0d/%0d expected 0/0", other, multi); end
    n_tests++; if (nbusy != 16) begin n_fail++; $display("FAIL simul_busy_cycles: got %0d expected 16", nbusy); end
    n_tests++; if (btn_level !== 4'b1111) begin n_fail++; $display("FAIL simul_level: got %b expected 1111", btn_level); end
  endtask

  task automatic test_enable();
    int nbusy = 0, bad = 0, rise = -1;
    do_reset(4'b0100, 0);
    for (int i = 0; i < 44; i++) begin
      step();
      if (busy) nbusy++;
      if (btn_level != 0 || btn_press != 0) bad++;
    end
    en = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (btn_level[2] && rise < 0) rise = cyc;
    end
    n_tests++; if (nbusy != 0) begin n_fail++; $display("FAIL enable_busy_gated: got %0d expected 0", nbusy); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL enable_no_change: got %0d expected 0", bad); end
    n_tests++; if (rise != 67) begin n_fail++; $display("FAIL enable_rise_cycle: got %0d expected 67", rise); end
  endtask

  task automatic test_reset_mid_scan();
    int first = -1;
    do_reset(4'b0011, 1);
    while (cyc < 33) step();
    n_tests++; if (btn_level !== 4'b0011 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b busy %b expected 0011 busy 1", btn_level, busy); end
    reset = 1;
    step();
    n_tests++; if ({btn_level, btn_press, btn_release, busy} !== 13'd0) begin n_fail++; $display("FAIL midrst_outputs: got %b expected 0", {btn_level, btn_press, btn_release, busy}); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state_q); end
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy && first < 0) first = cyc;
    end
    n_tests++; if (first != 42) begin n_fail++; $display("FAIL midrst_first_tick: got %0d expected 42", first); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_enable();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Time-multiplexed debounce controller for a bank of N mechanical buttons. It shares one tick generator and one compare/increment datapath across all inputs. On every sample tick it scans the buttons round-robin, one per clock, and updates a per-button stability counter. It sits between the raw board inputs and the user logic, and produces debounced levels plus one-cycle press/release pulses.

## Interface
- `N_BTN`, default 4: number of button inputs; legal range 1–16.
- `TICK_DIV`, default 1_000_000: clocks per sample tick (10 ms at 100 MHz); must be ≥ `N_BTN`+2.
- `STABLE_TICKS`, default 3: consecutive disagreeing samples required to flip a level; legal range 1–15.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: scan enable; when low, ticks do not start a scan.
- `btn_in` in N_BTN: raw asynchronous button inputs.
- `btn_level` out N_BTN: debounced level per button.
- `btn_press` out N_BTN: one-cycle pulse on a debounced 0→1 transition.
- `btn_release` out N_BTN: one-cycle pulse on a debounced 1→0 transition.
- `busy` out 1: high while the scan FSM is in SCAN.

## Operation
- Input path: each `btn_in` bit passes through a 2-flop synchronizer (`sync`) before use.
- Tick generation:
  - Counter runs 0..`TICK_DIV`-1 and wraps.
  - `tick` is high for one cycle when the count equals `TICK_DIV`-1.
  - The counter runs regardless of `en`.
- FSM states: IDLE, SCAN.
  - IDLE → SCAN when `tick && en`; `idx` is set to 0.
  - SCAN processes button `idx` each cycle.
  - SCAN → IDLE after processing `idx`==`N_BTN`-1. Otherwise `idx` increments.
  - A scan therefore lasts exactly `N_BTN` cycles.
- Per-button processing for button `i` = `idx`:
  - If `sync[i]` == `btn_level[i]`: `cnt[i]` ← 0.
  - Otherwise, if `cnt[i]`+1 == `STABLE_TICKS`:
    - `btn_level[i]` toggles and `cnt[i]` ← 0.
    - `btn_press[i]` pulses if the new level is 1; `btn_release[i]` pulses if the new level is 0.
  - Otherwise `cnt[i]` increments.
- Counter width is `$clog2(STABLE_TICKS+1)`. The counter never exceeds `STABLE_TICKS`-1, so there is no wrap.
- Only one button is updated per cycle, so at most one bit of `btn_press | btn_release` is high in any cycle.
- `en` deasserted mid-scan: the current scan completes. Only the start of a scan is gated; `cnt` values are retained.
- `tick` while in SCAN cannot occur because of the `TICK_DIV` constraint. If it did, it would be ignored.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0, `busy`=0, FSM=IDLE, `idx`=0, all `cnt`=0, synchronizer flops=0, tick counter=0.
- Reset asserted mid-scan: all of the above take effect on the next edge and the scan is abandoned.
- Synchronizer latency: 2 cycles from `btn_in` to `sync`.
- The IDLE→SCAN transition happens on the edge where `tick`=1. `busy` rises on that edge.
- Button `k` is processed in the (k+1)-th cycle of SCAN. Its `btn_level` and pulse outputs are registered and visible on the following edge.
- `busy` falls on the edge that processes `idx`=`N_BTN`-1.
- First tick occurs `TICK_DIV` cycles after reset deassertion (count 0 on the first post-reset cycle).
- Worst-case debounce latency from a stable input change: 2 + `STABLE_TICKS`·`TICK_DIV` + `N_BTN` cycles.

## Configuration
- `DEBOUNCE_RELEASE_EN` defined: `btn_release` is generated as described above.
- `DEBOUNCE_RELEASE_EN` undefined: `btn_release` is tied to 0 and its pulse logic is removed. `btn_press` and `btn_level` are unchanged.

## Structure
- Package `debounce_sched_pkg` contains:
  - `state_t` enum {IDLE, SCAN};
  - localparam helpers for counter width and index width (`$clog2(N_BTN)`, minimum 1).
- Sub-module `tick_gen` (parameter `TICK_DIV`; ports `clk`, `reset`, `tick`) is instantiated once.
- All remaining logic (synchronizer, FSM, per-button datapath) lives in the top module.

## Test plan
Bench parameters for all scenarios: `N_BTN`=4, `TICK_DIV`=8, `STABLE_TICKS`=3, `en`=1 unless stated.

- **Clean press:** hold `btn_in`=4'b0010 from cycle 0.
  - `btn_level[1]` rises after the third tick.
  - `btn_press` = 4'b0010 for exactly one cycle.
  - No other bits change.
- **Bounce rejection:** toggle `btn_in[0]` every 8 cycles for 64 cycles.
  - `cnt[0]` never reaches 3.
  - `btn_level`=0 and no pulses throughout.
- **Release:** after a debounced press of `btn_in[3]`, drive it to 0.
  - `btn_release`=4'b1000 for one cycle, 3 ticks later.
  - With the macro undefined, `btn_release` stays 0.
- **Simultaneous inputs:** drive `btn_in`=4'b1111 at once.
  - Press pulses appear on consecutive cycles in order bit0, bit1, bit2, bit3.
  - Never more than one bit per cycle.
  - `busy` is high for 4 cycles per tick.
- **Enable gating:** `en`=0 across 5 ticks with `btn_in`=4'b0100.
  - No scans and `busy`=0.
  - After re-enabling, the level rises after 3 further ticks.
- **Reset mid-scan:** assert `reset` during the second SCAN cycle while `btn_level`=4'b0011.
  - Next cycle: all outputs are 0 and the FSM is IDLE.
  - The first post-reset tick occurs 8 cycles later.
